// File: rtl/sram_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one asynchronous single-port SRAM,
// sequencing registered strobes over WAIT_CYCLES and latching read results.
module sram_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iread_ce,
    input  logic [31:0]       iram_addr,
    output logic [31:0]       ram_inst,
    output logic              irom_fin,
    input  logic              dread_ce,
    input  logic              dwrite_ce,
    input  logic [31:0]       dram_read_addr,
    input  logic [31:0]       dram_write_addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wbe,
    output logic [31:0]       ram_rdata,
    output logic              stall_mem,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [31:0]       sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    typedef enum logic [2:0] {StIdle, StIRd, StDRd, StDWr, StDWrec, StDone} state_e;
    typedef enum logic {GrInst, GrData} grant_e;

    localparam logic [3:0] CntLast = 4'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    grant_e            grant_q, grant_d, last_grant_q, last_grant_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       dq_o_q, dq_o_d;
    logic [3:0]        wbe_q, wbe_d;
    logic [31:0]       ram_inst_q, ram_inst_d, ram_rdata_q, ram_rdata_d;
    logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, dq_oe_q, dq_oe_d;
    logic [3:0]        be_n_q, be_n_d;
    logic              d_req, pick_data, d_fin;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{iram_addr, dram_read_addr, dram_write_addr};

    assign d_req     = dread_ce | dwrite_ce;
    // On a tie the port that was not served last wins.
    assign pick_data = d_req & (~iread_ce | (last_grant_q == GrInst));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        dq_o_d       = dq_o_q;
        wbe_d        = wbe_q;
        ram_inst_d   = ram_inst_q;
        ram_rdata_d  = ram_rdata_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (pick_data) begin
                    grant_d = GrData;
                    if (dwrite_ce) begin
                        state_d = StDWr;
                        addr_d  = dram_write_addr[ADDR_W+1:2];
                        dq_o_d  = wdata;
                        wbe_d   = wbe;
                    end else begin
                        state_d = StDRd;
                        addr_d  = dram_read_addr[ADDR_W+1:2];
                    end
                end else if (iread_ce) begin
                    grant_d = GrInst;
                    state_d = StIRd;
                    addr_d  = iram_addr[ADDR_W+1:2];
                end
            end
            StIRd, StDRd: begin
                if (cnt_q == CntLast) begin
                    cnt_d        = '0;
                    state_d      = StDone;
                    last_grant_d = grant_q;
                    if (state_q == StIRd) begin
                        ram_inst_d = sram_dq_i;
                    end else begin
                        ram_rdata_d = sram_dq_i;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDWr: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StDWrec;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDWrec: begin
                state_d      = StDone;
                last_grant_d = grant_q;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Pin values follow the next state so the strobes leave flops directly.
        ce_n_d  = ~(state_d inside {StIRd, StDRd, StDWr, StDWrec});
        oe_n_d  = ~(state_d inside {StIRd, StDRd});
        we_n_d  = (state_d != StDWr);
        dq_oe_d = state_d inside {StDWr, StDWrec};
        if (state_d inside {StIRd, StDRd}) begin
            be_n_d = 4'b0000;
        end else if (state_d inside {StDWr, StDWrec}) begin
            be_n_d = ~wbe_d;
        end else begin
            be_n_d = 4'b1111;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            grant_q      <= GrInst;
            last_grant_q <= GrInst;
            addr_q       <= '0;
            dq_o_q       <= '0;
            wbe_q        <= '0;
            ram_inst_q   <= '0;
            ram_rdata_q  <= '0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            dq_oe_q      <= 1'b0;
            be_n_q       <= 4'b1111;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            dq_o_q       <= dq_o_d;
            wbe_q        <= wbe_d;
            ram_inst_q   <= ram_inst_d;
            ram_rdata_q  <= ram_rdata_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            dq_oe_q      <= dq_oe_d;
            be_n_q       <= be_n_d;
        end
    end

    // A requester that withdrew mid-access gets no completion pulse.
    assign irom_fin  = (state_q == StDone) & (grant_q == GrInst) & iread_ce;
    assign d_fin     = (state_q == StDone) & (grant_q == GrData) & d_req;
    assign stall_mem = d_req & ~d_fin;

    assign ram_inst   = ram_inst_q;
    assign ram_rdata  = ram_rdata_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_be_n  = be_n_q;

endmodule
